// File: rtl/countdown_scheduler.sv
// Round-robin scheduler sharing one load/decrement down-counter among NUM_REQ requesters.
// Define SCHED_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-wins priority.
module countdown_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 3,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] load_val,
    input  logic                     en,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     busy,
    output logic [CNT_W-1:0]         count,
    output logic                     done,
    output logic [ID_W-1:0]          done_id
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state, state_next;
    logic [ID_W-1:0]      owner, owner_next;
    logic [ID_W-1:0]      ptr, ptr_next;
    logic [ID_W-1:0]      winner, idx;
    logic                 found;
    logic [NUM_REQ-1:0]   grant_next;
    logic                 busy_next, done_next;
    logic [CNT_W-1:0]     count_next;
    logic [ID_W-1:0]      done_id_next;
`ifndef SCHED_FIXED_PRIO_EN
    logic [ID_W-1:0]      ptr_after;

    assign ptr_after = (owner == ID_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
`endif

    // Search upward from the pointer, wrapping; with fixed priority the pointer stays 0.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((ptr + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_next   = state;
        owner_next   = owner;
        ptr_next     = ptr;
        grant_next   = grant;
        busy_next    = busy;
        count_next   = count;
        done_next    = 1'b0;
        done_id_next = done_id;
        unique case (state)
            IDLE: begin
                count_next = '1;
                if (found) begin
                    state_next = RUN;
                    owner_next = winner;
                    grant_next = NUM_REQ'(1) << winner;
                    count_next = load_val[winner*CNT_W +: CNT_W];
                    busy_next  = 1'b1;
                end
            end
            RUN: begin
                // Abort takes precedence over terminal count and ignores en.
                if (!req[owner]) begin
                    state_next = IDLE;
                    grant_next = '0;
                    count_next = '1;
                    busy_next  = 1'b0;
`ifndef SCHED_FIXED_PRIO_EN
                    ptr_next   = ptr_after;
`endif
                end else if (en) begin
                    if (count != '0) begin
                        count_next = count - 1'b1;
                    end else begin
                        state_next   = DONE;
                        done_next    = 1'b1;
                        done_id_next = owner;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
                grant_next = '0;
                count_next = '1;
                busy_next  = 1'b0;
`ifndef SCHED_FIXED_PRIO_EN
                ptr_next   = ptr_after;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            owner   <= '0;
            ptr     <= '0;
            grant   <= '0;
            busy    <= 1'b0;
            count   <= '1;
            done    <= 1'b0;
            done_id <= '0;
        end else begin
            state   <= state_next;
            owner   <= owner_next;
            ptr     <= ptr_next;
            grant   <= grant_next;
            busy    <= busy_next;
            count   <= count_next;
            done    <= done_next;
            done_id <= done_id_next;
        end
    end

endmodule

// File: tb/tb_countdown_scheduler.sv
// Scoreboarded bench for countdown_scheduler: directed jobs push expected done events,
// a monitor pops and checks them whenever done is high.
module tb_countdown_scheduler;

    localparam int NUM_REQ = 4;
    localparam int CNT_W   = 3;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*CNT_W-1:0] load_val;
    logic                     en;
    logic [NUM_REQ-1:0]       grant;
    logic                     busy;
    logic [CNT_W-1:0]         count;
    logic                     done;
    logic [1:0]               done_id;

    countdown_scheduler #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .load_val (load_val),
        .en       (en),
        .grant    (grant),
        .busy     (busy),
        .count    (count),
        .done     (done),
        .done_id  (done_id)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int id;
        int cyc;
    } done_t;

    done_t exp_q[$];
    int    checks = 0;
    int    passed = 0;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act == expv) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    endtask

    task automatic push(input int id, input int c);
        done_t e;
        e.id  = id;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        done_t e;
        if (reset && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", int'(done_id), -1);
            end else begin
                e = exp_q.pop_front();
                check("done_id", int'(done_id), e.id);
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    int c0;
    int rr_ids[4];
    int g;

    initial begin
        reset    = 1'b0;
        req      = '0;
        en       = 1'b0;
        load_val = '0;
        tick();
        tick();
        check("rst_grant", int'(grant), 0);
        check("rst_count", int'(count), 7);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_done_id", int'(done_id), 0);
        reset = 1'b1;
        tick();
        check("idle_count", int'(count), 7);

        // Single job: requester 2, start value 3
        req      = 4'b0100;
        load_val = {3'd0, 3'd3, 3'd0, 3'd0};
        en       = 1'b1;
        c0       = cyc;
        push(2, c0 + 5);
        tick();
        check("single_grant", int'(grant), 4);
        check("single_busy", int'(busy), 1);
        check("single_count0", int'(count), 3);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("single_count", int'(count), 3 - i);
        end
        tick();
        check("single_done_grant_held", int'(grant), 4);
        check("single_done_count_held", int'(count), 0);
        req = '0;
        tick();
        check("single_after_grant", int'(grant), 0);
        check("single_after_count", int'(count), 7);
        check("single_after_done", int'(done), 0);
        check("single_after_busy", int'(busy), 0);

        // Asynchronous reset mid-RUN: job is lost, no done
        req      = 4'b0001;
        load_val = {3'd0, 3'd0, 3'd0, 3'd5};
        tick();
        check("rstrun_grant_before", int'(grant), 1);
        #2 reset = 1'b0;
        #1;
        check("rstrun_grant", int'(grant), 0);
        check("rstrun_count", int'(count), 7);
        check("rstrun_busy", int'(busy), 0);
        check("rstrun_done", int'(done), 0);
        req = '0;
        tick();
        reset = 1'b1;
        tick();

        // Round-robin among requesters 0,1,3 with start value 1
`ifdef SCHED_FIXED_PRIO_EN
        rr_ids = '{0, 0, 0, 0};
`else
        rr_ids = '{0, 1, 3, 0};
`endif
        req      = 4'b1011;
        load_val = {3'd1, 3'd1, 3'd1, 3'd1};
        c0       = cyc;
        for (int j = 0; j < 4; j++) push(rr_ids[j], c0 + 3 + 4 * j);
        tick();
        for (int j = 0; j < 4; j++) begin
            g = 1 << rr_ids[j];
            check("rr_grant", int'(grant), g);
            tick();
            tick();
            if (j == 3) req = '0;
            tick();
            tick();
        end

        // Pause: en low for 4 cycles at count 3; later load_val change ignored
        req      = 4'b0001;
        load_val = {3'd0, 3'd0, 3'd0, 3'd5};
        c0       = cyc;
        push(0, c0 + 11);
        tick();
        check("pause_load", int'(count), 5);
        load_val = '0;
        tick();
        tick();
        check("pause_count_at_3", int'(count), 3);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("pause_hold", int'(count), 3);
        end
        en = 1'b1;
        tick();
        check("pause_resume", int'(count), 2);
        tick();
        tick();
        check("pause_zero", int'(count), 0);
        tick();
        req = '0;
        tick();
        tick();

        // Abort: owner 1 drops req at count 2, requester 2 wins next
        req      = 4'b0110;
        load_val = {3'd0, 3'd2, 3'd4, 3'd0};
        c0       = cyc;
        push(2, c0 + 8);
        tick();
        check("abort_grant", int'(grant), 2);
        check("abort_load", int'(count), 4);
        tick();
        tick();
        check("abort_count", int'(count), 2);
        req = 4'b0100;
        tick();
        check("abort_idle_grant", int'(grant), 0);
        check("abort_idle_count", int'(count), 7);
        check("abort_idle_busy", int'(busy), 0);
        tick();
        check("abort_next_grant", int'(grant), 4);
        check("abort_next_count", int'(count), 2);
        tick();
        tick();
        tick();
        req = '0;
        tick();
        tick();

        // Zero start value: done on the very next enabled edge
        req      = 4'b1000;
        load_val = {3'd0, 3'd5, 3'd5, 3'd5};
        c0       = cyc;
        push(3, c0 + 2);
        tick();
        check("zero_grant", int'(grant), 8);
        check("zero_count", int'(count), 0);
        tick();
        req = '0;
        tick();
        tick();
        tick();

        check("pending_done", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got cycle %0d expected finish", cyc);
        $fatal(1);
    end

endmodule

// File: doc/countdown_scheduler.md
Name: countdown_scheduler

Overview:
- Round-robin scheduler that shares a single 7-to-0 style down-counter resource between NUM_REQ requesters.
- A granted requester supplies a start value. The block loads it, decrements it under a global enable, and signals completion with a one-cycle done pulse plus the owner's ID.
- It sits between client blocks that need timed waits and the shared down-counter datapath. It owns the arbitration pointer and the load/decrement/finish sequencing.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CNT_W, 3, counter width; reload maximum is 2^CNT_W-1 (7 at default).
- ID_W, $clog2(NUM_REQ), localparam; width of requester index.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- req  input  NUM_REQ  per-requester request level; must be held until done or it aborts.
- load_val  input  NUM_REQ*CNT_W  start values; slice i = load_val[i*CNT_W +: CNT_W].
- en  input  1  global count enable; 0 pauses decrement, state frozen.
- grant  output  NUM_REQ  one-hot owner of the counter; all-zero when idle.
- busy  output  1  1 in RUN or DONE.
- count  output  CNT_W  current counter value.
- done  output  1  one-cycle pulse when owner's count completes.
- done_id  output  ID_W  index of finished requester; valid only while done=1.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, grant=0, busy=0, count={CNT_W{1}} (7), done=0, done_id=0.
  - RR pointer=0, so requester 0 has highest priority first.
- FSM states: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - If req!=0, select the first set bit searching from pointer upward, wrapping modulo NUM_REQ.
  - Next edge: grant=onehot(winner), count=load_val slice of winner, state=RUN, busy=1.
  - If req==0, stay in IDLE with count held at 7.
- RUN:
  - Abort: if req[owner]==0, go to IDLE on the next edge. grant=0, count=7, no done pulse, pointer=owner+1.
  - en=0: hold all state.
  - en=1, count>0: count=count-1.
  - en=1, count==0: state=DONE, done=1, done_id=owner; grant and count are held.
- DONE (exactly one cycle):
  - Next edge: state=IDLE, done=0, grant=0, count=7, pointer=(owner+1) mod NUM_REQ.
- Latency: with en held at 1 and no abort, done is high during the cycle that begins load_val+1 edges after the grant edge.
- load_val=0 is legal: count=0 in RUN, DONE follows on the next enabled edge.
- Arbitration happens only in IDLE. There is therefore one dead IDLE cycle between consecutive jobs, and no back-to-back grant.
- req changes on non-owner bits during RUN/DONE are ignored. Arbitration uses req values sampled in IDLE.
- Abort and count==0 in the same RUN cycle: abort wins, no done.
- Reset asserted mid-RUN: immediate return to reset values; the job is lost with no done.
- load_val is sampled only at the grant edge; later changes have no effect.

Optional Feature:
- Macro SCHED_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest-index asserted req always wins, and the pointer is unused (held at 0).
- Undefined (default): round-robin as described, with the pointer advancing past the last owner after DONE or abort.

Test Plan:
- Reset: reset=0 mid-simulation with req=4'b0001 active -> grant=0, count=7, busy=0, done=0 immediately, without waiting for a clk edge.
- Single job: req=4'b0100, slice2=3, en=1 -> grant=4'b0100; count 3,2,1,0; then done=1, done_id=2 for one cycle; then grant=0, count=7.
- Round-robin: req=4'b1011 held, all slices=1, en=1 -> grant order 0,1,3,0; each done_id matches. With SCHED_FIXED_PRIO_EN, every grant goes to 0.
- Pause: slice0=5, en=0 for 4 cycles after count reaches 3 -> count stays 3 during the pause; done arrives exactly 4 cycles later than with en=1.
- Abort and zero load: owner 1 drops req at count=2 -> IDLE next edge, no done, next winner is 2 if requesting. Slice3=0 -> RUN with count=0, done on the next edge with done_id=3.
